odev1_tt_driver: RTL and testbench

- Sequential stimulus driver and response capture for the 3-input gate network (`a`, `b`, `c` in; `f`, `q` out).
- On `start`, it walks `{a,b,c}` through all 8 combinations and waits a programmable settle time on each one.
- It samples `f`/`q` per vector into result vectors and, optionally, checks them against a built-in golden model.
- It sits on the driving side of the gate block, in bring-up and self-test of the lab design.

---
 rtl/odev1_pkg.sv | 22 ++
 rtl/odev1_golden.sv | 32 +++
 rtl/odev1_tt_driver.sv | 169 ++++++++++++++++
 tb/tb_odev1_tt_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/odev1_pkg.sv
// ---------------------------------------------------------------------------
// odev1_pkg
// Shared types and constants for the odev1 truth-table driver.
//   tt_state_t : sweep FSM states (IDLE, WAIT, SAMPLE, DONE)
//   EXP_F      : expected f response vector of the gate block (bit i = index i)
//   EXP_Q      : expected q response vector of the gate block
//   SETTLE_MAX : largest legal settle time in cycles
// ---------------------------------------------------------------------------
package odev1_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tt_state_t;

   localparam logic [7:0] EXP_F      = 8'h4B;
   localparam logic [7:0] EXP_Q      = 8'h00;
   localparam int         SETTLE_MAX = 15;

endpackage

// File: rtl/odev1_golden.sv
// ---------------------------------------------------------------------------
// odev1_golden
// Combinational reference of the 3-input gate network.
// Ports:
//   abc   in  3 : stimulus {a,b,c}
//   f_exp out 1 : expected f = XNOR(XOR(~a,b), NAND(b,c))
//   q_exp out 1 : expected q = NOR(XOR(~a,b), NAND(b,c), OR(~c,b))
// Only built when ODEV1_SELFCHECK_EN is defined.
// ---------------------------------------------------------------------------
import odev1_pkg::*;

module odev1_golden (
   input  logic [2:0] abc,
   output logic       f_exp,
   output logic       q_exp
);

   logic a, b, c;
   logic x_ab, n_bc, o_cb;

   assign a = abc[2];
   assign b = abc[1];
   assign c = abc[0];

   assign x_ab  = (~a) ^ b;
   assign n_bc  = ~(b & c);
   assign o_cb  = (~c) | b;

   assign f_exp = ~(x_ab ^ n_bc);
   assign q_exp = ~(x_ab | n_bc | o_cb);

endmodule

// File: rtl/odev1_tt_driver.sv
// ---------------------------------------------------------------------------
// odev1_tt_driver
// Sweeps {a,b,c} through indices 0..7, holds each vector SETTLE cycles,
// then captures f_in/q_in into f_vec/q_vec (bit i = response to index i).
// Optional self-check against the built-in golden model, enabled by the
// macro ODEV1_SELFCHECK_EN; without it err_cnt and pass are tied to 0.
// Parameters:
//   SETTLE : hold cycles per vector before sampling, legal 1..15
// Ports:
//   clk      in  1 : clock, rising edge
//   rst_n    in  1 : asynchronous active-low reset
//   start    in  1 : sweep request, honoured only in IDLE
//   a, b, c  out 1 : registered stimulus, {a,b,c} = current index
//   f_in     in  1 : f response of the gate block
//   q_in     in  1 : q response of the gate block
//   busy     out 1 : sweep in progress
//   done     out 1 : one-cycle completion pulse
//   f_vec    out 8 : captured f responses
//   q_vec    out 8 : captured q responses
//   err_cnt  out 4 : mismatching vectors (0..8)
//   pass     out 1 : no mismatches in the last completed sweep
// ---------------------------------------------------------------------------
import odev1_pkg::*;

module odev1_tt_driver #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       f_in,
   input  logic       q_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] f_vec,
   output logic [7:0] q_vec,
   output logic [3:0] err_cnt,
   output logic       pass
);

   // Out-of-range settings are pulled into 1..SETTLE_MAX so the 4-bit
   // wait counter always reaches its terminal value.
   localparam int SETTLE_C = (SETTLE < 1) ? 1 :
                             (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
   localparam logic [3:0] WCNT_LAST = 4'(SETTLE_C - 1);

   tt_state_t  state, state_next;
   logic [2:0] idx;
   logic [3:0] wcnt;
   logic [2:0] abc;
   logic       last_idx;

   assign last_idx = (idx == 3'd7);
   assign {a, b, c} = abc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (wcnt == WCNT_LAST) state_next = SAMPLE;
         end
         SAMPLE: begin
            busy       = 1'b1;
            state_next = last_idx ? DONE : WAIT;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stimulus is loaded on every entry to WAIT and dropped on entry to DONE,
   // so a/b/c are already valid in the first WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= 3'd0;
         wcnt  <= 4'd0;
         abc   <= 3'd0;
         f_vec <= 8'h00;
         q_vec <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx   <= 3'd0;
                  wcnt  <= 4'd0;
                  abc   <= 3'd0;
                  f_vec <= 8'h00;
                  q_vec <= 8'h00;
               end
            end
            WAIT: begin
               wcnt <= wcnt + 4'd1;
            end
            SAMPLE: begin
               f_vec[idx] <= f_in;
               q_vec[idx] <= q_in;
               if (last_idx) begin
                  abc <= 3'd0;
               end else begin
                  idx  <= idx + 3'd1;
                  wcnt <= 4'd0;
                  abc  <= idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ODEV1_SELFCHECK_EN
   logic f_exp, q_exp;
   logic mismatch;

   odev1_golden u_golden (
      .abc   (abc),
      .f_exp (f_exp),
      .q_exp (q_exp)
   );

   assign mismatch = ({f_in, q_in} != {f_exp, q_exp});

   // pass is decided on the final SAMPLE edge, so the last vector's
   // mismatch must be folded in directly rather than via err_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 4'd0;
         pass    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  err_cnt <= 4'd0;
                  pass    <= 1'b0;
               end
            end
            SAMPLE: begin
               if (mismatch) err_cnt <= err_cnt + 4'd1;
               if (last_idx) pass <= (err_cnt == 4'd0) && !mismatch;
            end
            default: ;
         endcase
      end
   end
`else
   assign err_cnt = 4'd0;
   assign pass    = 1'b0;
`endif

endmodule

// File: tb/tb_odev1_tt_driver.sv
// ---------------------------------------------------------------------------
// tb_odev1_tt_driver
// Drives two driver instances (SETTLE=2 and SETTLE=1) from a shared start and
// reset. Each instance sees a gate block emulated as an 8-entry truth table;
// the tables are correct, stuck, or random per sweep. Expected control
// timing and results come from the cycle arithmetic of the sweep and the
// published expected vectors.
// ---------------------------------------------------------------------------
module tb_odev1_tt_driver;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   always #5 clk = ~clk;

   logic       a2, b2, c2, f2, q2, busy2, done2, pass2;
   logic [7:0] fv2, qv2;
   logic [3:0] ec2;
   logic       a1, b1, c1, f1, q1, busy1, done1, pass1;
   logic [7:0] fv1, qv1;
   logic [3:0] ec1;

   logic [7:0] tf2 = 8'h4B, tq2 = 8'h00;
   logic [7:0] tf1 = 8'h4B, tq1 = 8'h00;

   assign f2 = tf2[{a2, b2, c2}];
   assign q2 = tq2[{a2, b2, c2}];
   assign f1 = tf1[{a1, b1, c1}];
   assign q1 = tq1[{a1, b1, c1}];

   odev1_tt_driver #(.SETTLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a2), .b(b2), .c(c2), .f_in(f2), .q_in(q2),
      .busy(busy2), .done(done2), .f_vec(fv2), .q_vec(qv2),
      .err_cnt(ec2), .pass(pass2)
   );

   odev1_tt_driver #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a1), .b(b1), .c(c1), .f_in(f1), .q_in(q1),
      .busy(busy1), .done(done1), .f_vec(fv1), .q_vec(qv1),
      .err_cnt(ec1), .pass(pass1)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {busy, done, a, b, c} in cycle n after the start edge, for settle s.
   function automatic logic [4:0] exp_ctrl(input int s, input int n);
      int per;
      per = s + 1;
      if (n >= 1 && n <= 8 * per) return {2'b10, 3'((n - 1) / per)};
      if (n == 8 * per + 1)       return 5'b01000;
      return 5'b00000;
   endfunction

   function automatic int popcnt8(input logic [7:0] v);
      int k;
      k = 0;
      for (int i = 0; i < 8; i++) k += int'(v[i]);
      return k;
   endfunction

   task automatic check_results(input string tag, input logic [7:0] tf, input logic [7:0] tq,
                                input logic [7:0] fv, input logic [7:0] qv,
                                input logic [3:0] ec, input logic ps);
      int e_err;
      logic e_pass;
`ifdef ODEV1_SELFCHECK_EN
      e_err  = popcnt8((tf ^ 8'h4B) | (tq ^ 8'h00));
      e_pass = (e_err == 0);
`else
      e_err  = 0;
      e_pass = 1'b0;
`endif
      chk({tag, "_fvec"}, 32'(fv), 32'(tf));
      chk({tag, "_qvec"}, 32'(qv), 32'(tq));
      chk({tag, "_err"},  32'(ec), 32'(e_err));
      chk({tag, "_pass"}, 32'(ps), 32'(e_pass));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rst2"}, 32'({a2, b2, c2, busy2, done2, pass2, fv2, qv2, ec2}), 32'd0);
      chk({tag, "_rst1"}, 32'({a1, b1, c1, busy1, done1, pass1, fv1, qv1, ec1}), 32'd0);
   endtask

   // One sweep: start sampled at edge k, then cycles n=1..32 are checked.
   // pulse_at injects an extra start pulse; abort_at asserts reset in that cycle.
   task automatic run_sweep(input string tag, input int pulse_at, input int abort_at);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         chk({tag, "_ctrl2"}, 32'({busy2, done2, a2, b2, c2}), 32'(exp_ctrl(2, n)));
         chk({tag, "_ctrl1"}, 32'({busy1, done1, a1, b1, c1}), 32'(exp_ctrl(1, n)));
         if (n == 1) begin
            chk({tag, "_clr2"}, 32'({fv2, qv2, ec2, pass2}), 32'd0);
            chk({tag, "_clr1"}, 32'({fv1, qv1, ec1, pass1}), 32'd0);
         end
         if (n == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals({tag, "_abort_now"});
            repeat (2) @(negedge clk);
            check_reset_vals({tag, "_abort_hold"});
            rst_n = 1'b1;
            for (int m = 0; m < 30; m++) begin
               @(negedge clk);
               check_reset_vals({tag, "_abort_idle"});
            end
            return;
         end
         if (n == 17) check_results({tag, "_res1"}, tf1, tq1, fv1, qv1, ec1, pass1);
         if (n == 25) check_results({tag, "_res2"}, tf2, tq2, fv2, qv2, ec2, pass2);
         if (n == 32) begin
            check_results({tag, "_hold1"}, tf1, tq1, fv1, qv1, ec1, pass1);
            check_results({tag, "_hold2"}, tf2, tq2, fv2, qv2, ec2, pass2);
         end
         start = (n == pulse_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_reset_vals("idle");
      end

      // correct gate block
      run_sweep("good", 0, 0);

      // f stuck at 1, extra start mid-sweep
      tf2 = 8'hFF; tq2 = 8'h00; tf1 = 8'hFF; tq1 = 8'h00;
      run_sweep("fstuck", 5, 0);

      // random gate behaviour, start pulse while the short instance is in DONE
      for (int s = 0; s < 4; s++) begin
         tf2 = 8'($urandom); tq2 = 8'($urandom);
         tf1 = 8'($urandom); tq1 = 8'($urandom);
         run_sweep("rand", (s == 0) ? 17 : 0, 0);
      end

      // reset during index 3 of the SETTLE=2 sweep, then a clean sweep
      tf2 = 8'h4B; tq2 = 8'h00; tf1 = 8'h4B; tq1 = 8'h00;
      run_sweep("abort", 0, 11);
      run_sweep("after", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
